// File: rtl/sextium_pkg.sv
// Shared types and constants for the Sextium memory-bus arbiter.
package sextium_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // One-hot {m1, m0} ownership view of a state.
  function automatic logic [1:0] state_to_grant(input arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    if (st == ST_GNT0) g = 2'b01;
    if (st == ST_GNT1) g = 2'b10;
    return g;
  endfunction

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer.
module mux2 #(
  parameter int W = 1
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/rr_pick2.sv
// Two-requester round-robin choose: a lone requester wins, a tie goes to
// the port that was not served last.
module rr_pick2
  import sextium_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_valid,
  output logic o_idx
);

  // Pick the winner from the current request pair and the last-served port.
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_idx   = PORT0;
    if (i_req0 && i_req1) begin
      o_idx = (i_last == PORT0) ? PORT1 : PORT0;
    end else if (i_req1) begin
      o_idx = PORT1;
    end
  end

endmodule

// File: rtl/sextium_mem_arbiter.sv
// Two-port memory-bus arbiter: Sextium core on port 0, loader/debug master on
// port 1. One owner per transfer, round-robin on ties, bus lock for port 1.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no owner; memory outputs forced to 0, mem_ack ignored
//   GNT0    | port 0 owns the bus; its strobes/addr/wdata reach memory
//   GNT1    | port 1 owns the bus; held while m1_lock even without request
module sextium_mem_arbiter
  import sextium_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant
);

  localparam int BUS_W = 2 + ADDR_W + DATA_W;

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;

  logic       w_req0;
  logic       w_req1;
  logic       w_pick_valid;
  logic       w_pick_idx;

  logic             w_owned;
  logic [BUS_W-1:0] w_bus0;
  logic [BUS_W-1:0] w_bus1;
  logic [BUS_W-1:0] w_bus_sel;
  logic [BUS_W-1:0] w_bus_out;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  rr_pick2 u_pick (
    .i_req0  (w_req0),
    .i_req1  (w_req1),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_idx   (w_pick_idx)
  );

  // State and last-served register; last resets to port 1 so port 0 wins
  // the first tie.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_last  <= PORT1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state: arbitration in IDLE, handover or retention on ack, and
  // release on withdrawal (port 1 lock overrides withdrawal).
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = (w_pick_idx == PORT1) ? ST_GNT1 : ST_GNT0;
        end
      end
      ST_GNT0: begin
        if (mem_ack) begin
          w_last_nxt = PORT0;
          if (w_req1)      w_state_nxt = ST_GNT1;
          else if (w_req0) w_state_nxt = ST_GNT0;
          else             w_state_nxt = ST_IDLE;
        end else if (!w_req0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GNT1: begin
        if (mem_ack) begin
          w_last_nxt = PORT1;
          if (m1_lock)     w_state_nxt = ST_GNT1;
          else if (w_req0) w_state_nxt = ST_GNT0;
          else if (w_req1) w_state_nxt = ST_GNT1;
          else             w_state_nxt = ST_IDLE;
        end else if (!w_req1 && !m1_lock) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_bus0 = {m0_read, m0_write, m0_addr, m0_wdata};
  assign w_bus1 = {m1_read, m1_write, m1_addr, m1_wdata};

  mux2 #(.W(BUS_W)) u_bus_mux (
    .i_sel (r_state == ST_GNT1),
    .i_d0  (w_bus0),
    .i_d1  (w_bus1),
    .o_y   (w_bus_sel)
  );

  // Memory-side outputs and acks follow the owner; everything is zero in IDLE.
  always_comb begin
    w_owned   = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    w_bus_out = '0;
    if (w_owned) begin
      w_bus_out = w_bus_sel;
    end
    m0_ack = mem_ack && (r_state == ST_GNT0);
    m1_ack = mem_ack && (r_state == ST_GNT1);
  end

  assign {mem_read, mem_write, mem_addr, mem_wdata} = w_bus_out;

  // Read data is broadcast; each master qualifies it with its own ack.
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  assign grant = state_to_grant(r_state);

endmodule

// File: tb/tb_sextium_mem_arbiter.sv
// Directed bench for sextium_mem_arbiter with a scoreboard queue of expected
// read data / memory addresses.
module tb_sextium_mem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          m0_read = 1'b0, m0_write = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;
  logic          m1_read = 1'b0, m1_write = 1'b0, m1_lock = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [1:0]    grant;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  sextium_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .m0_read   (m0_read),
    .m0_write  (m0_write),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_read   (m1_read),
    .m1_write  (m1_write),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
    .m1_lock   (m1_lock),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .grant     (grant)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset held with both ports requesting and a stale ack.
    m0_read = 1'b1; m1_read = 1'b1; mem_ack = 1'b1;
    repeat (3) step();
    settle();
    chk("rst_grant", grant, 2'b00);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);

    step(); reset = 1'b1; mem_ack = 1'b0; m0_addr = 16'h0033; settle();
    chk("rel_idle_grant", grant, 2'b00);

    // First tie after reset goes to port 0.
    step(); settle();
    chk("rel_grant", grant, 2'b01);
    chk("rel_mem_read", mem_read, 1'b1);
    chk("rel_mem_addr", mem_addr, 16'h0033);

    // Withdrawal without ack.
    step(); m0_read = 1'b0; m1_read = 1'b0; settle();
    chk("wd_grant_hold", grant, 2'b01);
    chk("wd_strobe_low", mem_read, 1'b0);
    step(); m0_read = 1'b1; m1_read = 1'b1; settle();
    chk("wd_idle", grant, 2'b00);
    chk("wd_idle_read", mem_read, 1'b0);
    step(); m0_read = 1'b0; m1_read = 1'b0; settle();
    chk("wd_tie_port0", grant, 2'b01);
    step(); settle();
    chk("wd_idle2", grant, 2'b00);

    // Single read, ack two cycles after strobes appear.
    step(); m0_read = 1'b1; m0_addr = 16'h0012; exp_q.push_back(16'hBEEF); settle();
    chk("rd_idle", grant, 2'b00);
    step(); settle();
    chk("rd_grant", grant, 2'b01);
    chk("rd_mem_read", mem_read, 1'b1);
    chk("rd_mem_addr", mem_addr, 16'h0012);
    chk("rd_no_ack1", m0_ack, 1'b0);
    step(); settle();
    chk("rd_no_ack2", m0_ack, 1'b0);
    step(); mem_ack = 1'b1; mem_rdata = 16'hBEEF; settle();
    chk("rd_m0_ack", m0_ack, 1'b1);
    chk("rd_m1_ack", m1_ack, 1'b0);
    pop_chk("rd_m0_rdata", m0_rdata);
    step(); m0_read = 1'b0; mem_ack = 1'b0; settle();
    chk("rd_regrant", grant, 2'b01);
    chk("rd_ack_one_cycle", m0_ack, 1'b0);
    chk("rd_strobe_low", mem_read, 1'b0);
    step(); settle();
    chk("rd_idle_after", grant, 2'b00);

    // Contention: last served is port 0, so port 1 goes first.
    step();
    m0_write = 1'b1; m0_addr = 16'h0001; m0_wdata = 16'h1111;
    m1_write = 1'b1; m1_addr = 16'h0002; m1_wdata = 16'h2222;
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 16'h0002 : 16'h0001);
    settle();
    chk("ct_stale_ack0", m0_ack, 1'b0);
    chk("ct_stale_ack1", m1_ack, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(); settle();
      pop_chk("ct_mem_addr", mem_addr);
      chk("ct_mem_write", mem_write, 1'b1);
      chk("ct_mem_wdata", mem_wdata, (i % 2 == 0) ? 16'h2222 : 16'h1111);
      chk("ct_m1_ack", m1_ack, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("ct_m0_ack", m0_ack, (i % 2 == 0) ? 1'b0 : 1'b1);
    end
    step(); m0_write = 1'b0; m1_write = 1'b0; mem_ack = 1'b0; settle();
    chk("ct_tail_grant", grant, 2'b10);
    chk("ct_tail_write", mem_write, 1'b0);
    step(); settle();
    chk("ct_idle", grant, 2'b00);

    // Locked burst from port 1 while port 0 waits.
    step();
    m1_lock = 1'b1; m1_write = 1'b1; m1_addr = 16'h0100; m1_wdata = 16'h00A0;
    m0_read = 1'b1; m0_addr = 16'h0040;
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0101); exp_q.push_back(16'h0102);
    settle();
    chk("lk_idle", grant, 2'b00);
    step(); mem_ack = 1'b1; settle();
    chk("lk_grant1", grant, 2'b10);
    chk("lk_write1", mem_write, 1'b1);
    chk("lk_m0_masked", mem_read, 1'b0);
    chk("lk_m1_ack1", m1_ack, 1'b1);
    chk("lk_m0_ack1", m0_ack, 1'b0);
    pop_chk("lk_addr1", mem_addr);
    step(); m1_addr = 16'h0101; settle();
    chk("lk_grant2", grant, 2'b10);
    chk("lk_m1_ack2", m1_ack, 1'b1);
    pop_chk("lk_addr2", mem_addr);
    step(); m1_write = 1'b0; mem_ack = 1'b0; settle();
    chk("lk_hold_grant", grant, 2'b10);
    chk("lk_hold_write", mem_write, 1'b0);
    chk("lk_hold_read", mem_read, 1'b0);
    chk("lk_hold_m0_ack", m0_ack, 1'b0);
    step(); settle();
    chk("lk_hold_grant2", grant, 2'b10);
    chk("lk_hold_read2", mem_read, 1'b0);
    step(); m1_write = 1'b1; m1_addr = 16'h0102; m1_lock = 1'b0; mem_ack = 1'b1; settle();
    chk("lk_grant3", grant, 2'b10);
    chk("lk_m1_ack3", m1_ack, 1'b1);
    pop_chk("lk_addr3", mem_addr);
    step(); m1_write = 1'b0; mem_rdata = 16'h1234; exp_q.push_back(16'h1234); settle();
    chk("lk_m0_grant", grant, 2'b01);
    chk("lk_m0_read", mem_read, 1'b1);
    chk("lk_m0_addr", mem_addr, 16'h0040);
    chk("lk_m0_ack", m0_ack, 1'b1);
    chk("lk_m1_rdata", m1_rdata, 16'h1234);
    pop_chk("lk_m0_rdata", m0_rdata);
    step(); m0_read = 1'b0; mem_ack = 1'b0; settle();
    chk("lk_tail_grant", grant, 2'b01);
    chk("lk_tail_read", mem_read, 1'b0);
    step(); settle();
    chk("lk_idle2", grant, 2'b00);

    // Asynchronous reset in the middle of a port-1 transfer.
    step(); m1_write = 1'b1; m1_addr = 16'h0200; settle();
    chk("mr_idle", grant, 2'b00);
    step(); mem_ack = 1'b1; settle();
    chk("mr_grant", grant, 2'b10);
    chk("mr_write", mem_write, 1'b1);
    chk("mr_m1_ack", m1_ack, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("mr_write_low", mem_write, 1'b0);
    chk("mr_ack_low", m1_ack, 1'b0);
    chk("mr_grant_low", grant, 2'b00);
    chk("mr_addr_low", mem_addr, 16'h0000);

    step(); reset = 1'b1; m1_write = 1'b0; mem_ack = 1'b0; settle();
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
